// File: rtl/param_sync_ram.sv
// param_sync_ram
//   Parametrised single-clock RAM with one write port and one read port. Read data
//   is registered and qualified by a one-cycle rd_valid strobe. After reset the
//   array is cleared by an init sweep that writes INIT_VAL to every word. Requests
//   are ignored while the sweep runs.
//
//   Optional feature macro: MEM_PARITY_EN
//     When defined, each word carries an even-parity bit. wr_par_inv corrupts that
//     bit on a write. rd_par_err flags a mismatch on the word returned in rd_data.
//
//   Ports
//     clk        in   1       clock, rising edge
//     rst_n      in   1       asynchronous active-low reset
//     wr_en      in   1       write request (ignored while init_busy=1)
//     wr_addr    in   ADDR_W  write address
//     wr_data    in   DATA_W  write data
//     rd_en      in   1       read request (ignored while init_busy=1)
//     rd_addr    in   ADDR_W  read address
//     rd_data    out  DATA_W  registered read data, holds between reads
//     rd_valid   out  1       pulse: rd_data was updated by this cycle's edge
//     wr_par_inv in   1       [MEM_PARITY_EN] invert stored parity on this write
//     rd_par_err out  1       [MEM_PARITY_EN] parity mismatch on word in rd_data
//     init_busy  out  1       high while the init sweep runs
module param_sync_ram #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
`ifdef MEM_PARITY_EN
  input  logic              wr_par_inv,
  output logic              rd_par_err,
`endif
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              rd_fire;

  // Stored word format: parity bit (when enabled) above the data bits.
`ifdef MEM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign wr_word   = {(^wr_data) ^ wr_par_inv, wr_data};
`else
  assign init_word = INIT_VAL;
  assign wr_word   = wr_data;
`endif

  assign init_busy = (state == INIT);
  assign rd_fire   = (state == READY) && rd_en;
  assign rd_word   = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // The sweep leaves INIT on the edge that writes the last word.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == {ADDR_W{1'b1}}) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // The array has no reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= init_word;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Reading the array with a non-blocking update gives read-first behaviour on
  // a same-address read/write collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef MEM_PARITY_EN
      rd_par_err <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= rd_word[DATA_W-1:0];
      end
`ifdef MEM_PARITY_EN
      rd_par_err <= rd_fire ? ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]) : 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_param_sync_ram.sv
// tb_param_sync_ram
//   Self-checking bench for param_sync_ram (DATA_W=4, ADDR_W=2, INIT_VAL=5).
//   A word-level memory model predicts read data; inputs change and outputs are
//   sampled on the falling clock edge.
module tb_param_sync_ram;

  localparam int DEPTH = 4;
  localparam logic [3:0] INIT_V = 4'h5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       init_busy;
`ifdef MEM_PARITY_EN
  logic       wr_par_inv;
  logic       rd_par_err;
  logic       bad [DEPTH];
  logic       exp_perr;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [3:0] model [DEPTH];
  logic [3:0] exp_data;
  logic       exp_valid;

  param_sync_ram #(.DATA_W(4), .ADDR_W(2), .INIT_VAL(INIT_V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
`ifdef MEM_PARITY_EN
    .wr_par_inv(wr_par_inv),
    .rd_par_err(rd_par_err),
`endif
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReady(input string tag);
    checkOutput({tag, ".valid"}, {3'b0, rd_valid}, {3'b0, exp_valid});
    checkOutput({tag, ".data"}, rd_data, exp_data);
    checkOutput({tag, ".busy"}, {3'b0, init_busy}, 4'h0);
`ifdef MEM_PARITY_EN
    checkOutput({tag, ".perr"}, {3'b0, rd_par_err}, {3'b0, exp_perr});
`endif
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = INIT_V;
`ifdef MEM_PARITY_EN
      bad[i] = 1'b0;
`endif
    end
    exp_data  = 4'h0;
    exp_valid = 1'b0;
`ifdef MEM_PARITY_EN
    exp_perr = 1'b0;
`endif
  endtask

  // One READY-state cycle: drive at the falling edge, update the model at the
  // rising edge (read sees the old word), check at the next falling edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] wa,
                               input logic [3:0] wd, input logic re, input logic [1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(posedge clk);
    exp_valid = re;
    if (re) exp_data = model[ra];
`ifdef MEM_PARITY_EN
    exp_perr = re ? bad[ra] : 1'b0;
    if (we) bad[wa] = wr_par_inv;
`endif
    if (we) model[wa] = wd;
    @(negedge clk);
    checkReady(tag);
  endtask

  // Called at a falling edge with rst_n low. Releases reset with rd_en and a
  // write to addr 2 held active, which the sweep must ignore.
  task automatic runInit(input string tag);
    resetModel();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h9; rd_en = 1'b1; rd_addr = 2'd0;
    rst_n = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      checkOutput($sformatf("%s.busy%0d", tag, k), {3'b0, init_busy},
                  (k < DEPTH) ? 4'h1 : 4'h0);
      checkOutput($sformatf("%s.valid%0d", tag, k), {3'b0, rd_valid}, 4'h0);
      if (k < DEPTH) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
`ifdef MEM_PARITY_EN
    wr_par_inv = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", {3'b0, init_busy}, 4'h1);
    checkOutput("reset.valid", {3'b0, rd_valid}, 4'h0);
    checkOutput("reset.data", rd_data, 4'h0);

    // Init sweep, then every word reads INIT_VAL (addr 2 ignored the INIT write).
    runInit("init1");
    for (int a = 0; a < DEPTH; a++)
      applyStimulus($sformatf("initrd%0d", a), 1'b0, 2'd0, 4'h0, 1'b1, 2'(a));

    // Writes, then back-to-back reads.
    applyStimulus("wr0", 1'b1, 2'd0, 4'hF, 1'b0, 2'd0);
    applyStimulus("wr1", 1'b1, 2'd1, 4'h3, 1'b0, 2'd0);
    applyStimulus("wr2", 1'b1, 2'd2, 4'hC, 1'b0, 2'd0);
    applyStimulus("wr3", 1'b1, 2'd3, 4'h0, 1'b0, 2'd0);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus($sformatf("b2b%0d", a), 1'b0, 2'd0, 4'h0, 1'b1, 2'(a));

    // Same-address collision returns the old word; next read sees the new one.
    applyStimulus("coll", 1'b1, 2'd1, 4'hA, 1'b1, 2'd1);
    applyStimulus("coll.next", 1'b0, 2'd0, 4'h0, 1'b1, 2'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 40; i++)
      applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)));

`ifdef MEM_PARITY_EN
    wr_par_inv = 1'b1;
    applyStimulus("par.badwr", 1'b1, 2'd3, 4'h6, 1'b0, 2'd0);
    wr_par_inv = 1'b0;
    applyStimulus("par.badrd", 1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
    applyStimulus("par.goodwr", 1'b1, 2'd3, 4'h6, 1'b0, 2'd0);
    applyStimulus("par.goodrd", 1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
`endif

    // Reset in the middle of a read burst takes effect without a clock edge.
    applyStimulus("burst0", 1'b0, 2'd0, 4'h0, 1'b1, 2'd0);
    applyStimulus("burst1", 1'b0, 2'd0, 4'h0, 1'b1, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid", {3'b0, rd_valid}, 4'h0);
    checkOutput("midrst.busy", {3'b0, init_busy}, 4'h1);
    checkOutput("midrst.data", rd_data, 4'h0);
    @(negedge clk);
    runInit("init2");
    for (int a = 0; a < DEPTH; a++)
      applyStimulus($sformatf("postrst%0d", a), 1'b0, 2'd0, 4'h0, 1'b1, 2'(a));
    applyStimulus("idle", 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
